// File: rtl/fetch_stage.sv
// Y86-style fetch stage: decodes the ten bytes at the PC into a registered
// output record and advances or parks the PC according to the fetched opcode.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_BYTES = 128
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc_out,
  output logic [2:0]  stat
);

  typedef enum logic [1:0] {RUN, WAIT_RET, HALTED, ERROR} state_t;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  state_t      r_state, w_next;
  logic [63:0] r_pc;
  logic        r_out_valid;
  logic [3:0]  r_icode, r_ifun, r_ra, r_rb;
  logic [63:0] r_valc, r_valp, r_pc_out;
  logic [2:0]  r_stat;

  logic [3:0]  w_icode, w_ifun, w_len, w_ra, w_rb;
  logic [63:0] w_valc, w_valp, w_next_pc;
  logic [64:0] w_end;
  logic        w_ins_bad, w_adr_bad, w_capture;
  logic [2:0]  w_stat;

  assign w_icode = imem_data[7:4];
  assign w_ifun  = imem_data[3:0];

  always_comb begin
    w_len     = 4'd1;
    w_ra      = 4'hF;
    w_rb      = 4'hF;
    w_valc    = 64'h0;
    w_ins_bad = 1'b0;
    case (w_icode)
      4'h0, 4'h1, 4'h9: w_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: w_len = 4'd2;
      4'h7, 4'h8: w_len = 4'd9;
      4'h3, 4'h4, 4'h5: w_len = 4'd10;
      default: w_len = 4'd1;
    endcase
    case (w_icode)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: begin
        w_ra = imem_data[15:12];
        w_rb = imem_data[11:8];
      end
      default: ;
    endcase
    case (w_icode)
      4'h3, 4'h4, 4'h5: w_valc = imem_data[79:16];
      4'h7, 4'h8:       w_valc = imem_data[71:8];
      default: ;
    endcase
    case (w_icode)
      4'h2, 4'h7: w_ins_bad = (w_ifun > 4'd6);
      4'h6:       w_ins_bad = (w_ifun > 4'd3);
      4'hC, 4'hD, 4'hE, 4'hF: w_ins_bad = 1'b1;
      default:    w_ins_bad = (w_ifun != 4'd0);
    endcase
  end

  // Sum is one bit wider so a PC near 2^64 cannot wrap past the bound check.
  assign w_end     = {1'b0, r_pc} + {61'b0, w_len};
  assign w_adr_bad = (w_end > 65'(MEM_BYTES));
  assign w_valp    = r_pc + {60'b0, w_len};
  assign w_next_pc = (w_icode == 4'h7 || w_icode == 4'h8) ? w_valc : w_valp;

  always_comb begin
    w_stat = ST_AOK;
    if (w_adr_bad)             w_stat = ST_ADR;
    else if (w_ins_bad)        w_stat = ST_INS;
    else if (w_icode == 4'h0)  w_stat = ST_HLT;
  end

  assign w_capture = (r_state == RUN) && (!r_out_valid || out_ready) && !redirect_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next;
  end

  // A faulting fetch parks in ERROR even when the opcode is a ret.
  always_comb begin
    w_next = r_state;
    if (redirect_valid) begin
      w_next = RUN;
    end else if (w_capture) begin
      if (w_stat == ST_ADR || w_stat == ST_INS) w_next = ERROR;
      else if (w_stat == ST_HLT)                w_next = HALTED;
      else if (w_icode == 4'h9)                 w_next = WAIT_RET;
      else                                      w_next = RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_icode     <= 4'h0;
      r_ifun      <= 4'h0;
      r_ra        <= 4'hF;
      r_rb        <= 4'hF;
      r_valc      <= 64'h0;
      r_valp      <= 64'h0;
      r_pc_out    <= 64'h0;
      r_stat      <= ST_AOK;
    end else if (redirect_valid) begin
      r_pc        <= redirect_pc;
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_pc        <= w_next_pc;
      r_out_valid <= 1'b1;
      r_icode     <= w_icode;
      r_ifun      <= w_ifun;
      r_ra        <= w_ra;
      r_rb        <= w_rb;
      r_valc      <= w_valc;
      r_valp      <= w_valp;
      r_pc_out    <= r_pc;
      r_stat      <= w_stat;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign icode     = r_icode;
  assign ifun      = r_ifun;
  assign rA        = r_ra;
  assign rB        = r_rb;
  assign valC      = r_valc;
  assign valP      = r_valp;
  assign pc_out    = r_pc_out;
  assign stat      = r_stat;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning PC loaded on reset.
REQ-002 SHALL have parameter MEM_BYTES, default 128, meaning instruction memory size in bytes.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 64, byte address to instruction memory; equals the PC register.
REQ-006 SHALL have port imem_data, input, 80, ten bytes at imem_addr, little-endian (byte0 in [7:0]), combinational from imem_addr.
REQ-007 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 64), a PC correction from downstream.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the output handshake.
REQ-009 SHALL have registered outputs icode (4), ifun (4), rA (4), rB (4), valC (64), valP (64), pc_out (64), stat (3).

Function
REQ-010 SHALL use states RUN, WAIT_RET, HALTED, ERROR.
REQ-011 SHALL decode byte0 as icode = [7:4], ifun = [3:0].
REQ-012 SHALL use instruction lengths: icode 0, 1, 9 = 1 byte; 2, 6, A, B = 2 bytes; 7, 8 = 9 bytes; 3, 4, 5 = 10 bytes.
REQ-013 SHALL take rA/rB from byte1 [7:4]/[3:0] when icode is 2-6, A or B; otherwise both SHALL be 4'hF.
REQ-014 SHALL take valC from bytes 2-9 for icode 3-5, from bytes 1-8 for icode 7-8, and 0 otherwise.
REQ-015 SHALL compute valP as PC + length, modulo 2^64.
REQ-016 SHALL flag an invalid instruction when icode > B, or when ifun is out of range: ifun > 6 for icode 2 or 7, ifun > 3 for icode 6, ifun != 0 for all other icodes.
REQ-017 SHALL flag an address error when PC + length > MEM_BYTES.
REQ-018 SHALL set stat to 3 (ADR) on an address error, else 4 (INS) on an invalid instruction, else 2 (HLT) for icode 0, else 1 (AOK).
REQ-019 SHALL capture a fetch in RUN when out_valid == 0 or out_ready == 1: load all output fields, set out_valid = 1, and set pc_out = PC.
REQ-020 SHALL, on capture, load PC with valC for icode 7 or 8, and with valP otherwise.
REQ-021 SHALL change state on capture: icode 9 -> WAIT_RET; stat HLT -> HALTED; stat ADR/INS -> ERROR; otherwise stay in RUN.
REQ-022 SHALL hold PC and all output fields stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid on a handshake (out_valid && out_ready) when no capture occurs in the same cycle.
REQ-024 SHALL NOT capture in WAIT_RET, HALTED or ERROR; the PC SHALL be held.
REQ-025 SHALL give redirect_valid highest priority in every state: PC <= redirect_pc, out_valid <= 0 (flush, no handshake required), state <= RUN, and no capture that cycle.
REQ-026 SHALL NOT wrap imem_addr or index memory itself; the address-error check covers out-of-range addresses.

Reset
REQ-027 SHALL, on reset, immediately set PC = RESET_PC, state = RUN, out_valid = 0, icode = ifun = 0, rA = rB = F, valC = valP = pc_out = 0, and stat = 1.
REQ-028 SHALL abandon any pending fetch or handshake when reset asserts mid-operation, and SHALL begin fetching on the first rising edge after deassertion.

Verification
REQ-029 Memory 30 F2 08 00.. at PC 0, out_ready = 1 -> next edge: icode 3, rB 2, valC 8, valP 10 (0xA), PC 10.
REQ-030 Memory 70 40 00.. (jmp 0x40) at PC 0 -> valC 0x40, valP 9, next imem_addr 0x40.
REQ-031 Memory 90 (ret) -> one capture, then out_valid drops after handshake and PC holds; redirect_valid with redirect_pc 0x20 -> fetch resumes at 0x20.
REQ-032 out_ready held 0 for 3 cycles after a capture -> all fields and PC unchanged; out_ready = 1 -> next instruction captured on the same edge.
REQ-033 PC 0x7C with byte 0x30 -> stat 3 and state ERROR; byte 0xC0 at a valid PC -> stat 4; byte 0x00 -> stat 2 and HALTED, with no further captures.
REQ-034 redirect_valid while out_valid = 1 and out_ready = 0 -> out_valid = 0 next cycle and PC = redirect_pc; reset asserted mid-stall -> PC = 0 and out_valid = 0 asynchronously.
